multicycle_seq_ctrl: RTL

- Phase sequencer for the multi-cycle RV32 subset core (jal, lw, sw, beq/blt, R-type ALU, I-type ALU).
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the main decoder's enable (control_on) and gates the IR load, PC update and register writeback.
- Handshakes with the shared memory port, detects illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/multicycle_seq_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/multicycle_seq_ctrl.sv
// Phase sequencer for the multi-cycle RV32 subset core: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, handshakes with the shared memory port and counts retirements.
module multicycle_seq_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             halt_req,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_load,
    output logic             control_on,
    output logic             pc_write,
    output logic             wb_en,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t            st;
    logic [WAIT_W-1:0] wait_cnt;
    logic [6:0]        op_q;
    logic              op_legal;

    always_comb begin
        op_legal = (opcode == OP_JAL)    || (opcode == OP_LOAD) ||
                   (opcode == OP_STORE)  || (opcode == OP_BRANCH) ||
                   (opcode == OP_ALU)    || (opcode == OP_ALUI);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            wait_cnt <= '0;
            op_q     <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
            retired  <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (run) st <= FETCH;
                end
                FETCH, MEM: begin
                    // Timeout fires on the TIMEOUT-th consecutive wait cycle, checked before incrementing.
                    if (mem_ready) begin
                        wait_cnt <= '0;
                        st       <= (st == FETCH) ? DECODE : WB;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        bus_err  <= 1'b1;
                        st       <= HALT;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                DECODE: begin
                    op_q <= opcode;
                    if (op_legal) begin
                        st <= EXEC;
                    end else begin
                        illegal <= 1'b1;
                        st      <= HALT;
                    end
                end
                EXEC: begin
                    st <= (op_q == OP_LOAD || op_q == OP_STORE) ? MEM : WB;
                end
                WB: begin
                    retired <= retired + CNT_W'(1);
                    if (halt_req)  st <= HALT;
                    else if (!run) st <= IDLE;
                    else           st <= FETCH;
                end
                HALT: st <= HALT;
                default: st <= IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_load    = 1'b0;
        control_on = 1'b0;
        pc_write   = 1'b0;
        wb_en      = 1'b0;
        case (st)
            FETCH: begin
                imem_req = 1'b1;
                ir_load  = mem_ready;
            end
            DECODE, EXEC: control_on = 1'b1;
            MEM: begin
                control_on = 1'b1;
                dmem_req   = 1'b1;
            end
            WB: begin
                control_on = 1'b1;
                pc_write   = 1'b1;
                wb_en      = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = st;

endmodule
